// File: rtl/arb8way16.sv
// Round-robin arbiter for eight 16-bit requesters feeding one registered valid/ready output stage.
// Optional grant locking is compiled in with `define ARB_LOCK_EN.
//
// state | meaning
// EMPTY | output register holds no word (out_valid=0)
// FULL  | output register holds a word awaiting the consumer (out_valid=1)
module arb8way16 #(
  parameter logic [2:0] RESET_PTR = 3'd7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   req,
  input  logic [127:0] din,
  input  logic [7:0]   lock,
  output logic [7:0]   ack,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [15:0]  out_data,
  output logic [2:0]   out_sel
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t     state;
  logic [2:0] ptr;
  logic [2:0] win;
  logic [2:0] idx;
  logic       found;
  logic       load;
  logic       lock_hold;

  assign load = (state == EMPTY) | (out_valid & out_ready);

`ifdef ARB_LOCK_EN
  assign lock_hold = lock[ptr] & req[ptr];
`else
  // lock has no effect in this build
  assign lock_hold = 1'b0 & lock[ptr];
`endif

  // ptr itself is scanned last so a lone requester keeps winning
  always_comb begin
    win   = ptr;
    idx   = ptr;
    found = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      idx = ptr + 3'(k);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    if (lock_hold) win = ptr;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      out_data  <= 16'h0000;
      out_sel   <= 3'd0;
      ack       <= 8'h00;
      ptr       <= RESET_PTR;
    end else begin
      ack <= 8'h00;
      if (load) begin
        if (req != 8'h00) begin
          state     <= FULL;
          out_valid <= 1'b1;
          out_data  <= din[{win, 4'b0000} +: 16];
          out_sel   <= win;
          ptr       <= win;
          ack       <= 8'h01 << win;
        end else begin
          state     <= EMPTY;
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule
